nibble_add_sequencer: RTL and testbench

Multi-cycle 32-bit adder controller that adds two operands one 4-bit slice per clock, least-significant slice first, with a registered ripple carry between slices. It sits directly upstream of the 3-to-8 slice decoder. Each cycle it drives a 3-bit slice index `sel` and a qualifier `sel_en`; the decoder turns these into one-hot slice strobes. The block also accumulates the full sum internally and reports completion through a start/busy/done handshake.

---
 rtl/nibble_seq_pkg.sv | 15 +
 rtl/nibble_add_sequencer_slice_adder.sv | 16 +
 rtl/nibble_add_sequencer.sv | 121 ++++++++++++
 tb/tb_nibble_add_sequencer.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/nibble_seq_pkg.sv
// Shared types and constants for the nibble-serial adder controller.
package nibble_seq_pkg;

    localparam int N_SLICES = 8;
    localparam int SEL_W    = 3;

    localparam logic [SEL_W-1:0] LAST_SLICE = SEL_W'(N_SLICES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/nibble_add_sequencer_slice_adder.sv
// slice_adder: SLICE_W-bit adder with carry in/out.
// Latency: combinational. Backpressure: none.
// No internal state.
module slice_adder #(
    parameter int SLICE_W = 4
) (
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               ci,
    output logic [SLICE_W-1:0] s,
    output logic               co
);

    assign {co, s} = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, ci};

endmodule

// File: rtl/nibble_add_sequencer.sv
// Adds two 8-slice operands one slice per clock, LSB slice first; optional ovf via NIBBLE_SEQ_OVF_EN.
// Latency: 9 cycles start->done, one operation per 10 cycles.
// Backpressure: start is taken only in IDLE and dropped (not queued) while busy.
module nibble_add_sequencer
    import nibble_seq_pkg::*;
#(
    parameter int SLICE_W = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [N_SLICES*SLICE_W-1:0] a,
    input  logic [N_SLICES*SLICE_W-1:0] b,
    input  logic                        cin,
    output logic [SEL_W-1:0]            sel,
    output logic                        sel_en,
    output logic                        busy,
    output logic                        done,
    output logic [N_SLICES*SLICE_W-1:0] sum,
    output logic                        cout
`ifdef NIBBLE_SEQ_OVF_EN
    ,
    output logic                        ovf
`endif
);

    seq_state_t state_q, state_d;

    logic [SEL_W-1:0]                  cnt_q;
    logic [N_SLICES-1:0][SLICE_W-1:0]  opa_q, opb_q, sum_q;
    logic                              carry_q;
    logic                              cout_q;

    logic [SLICE_W-1:0] sl_s;
    logic               sl_c;

    slice_adder #(
        .SLICE_W (SLICE_W)
    ) u_slice_adder (
        .a  (opa_q[cnt_q]),
        .b  (opb_q[cnt_q]),
        .ci (carry_q),
        .s  (sl_s),
        .co (sl_c)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        sel     = '0;
        sel_en  = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_RUN;
            end
            ST_RUN: begin
                sel    = cnt_q;
                sel_en = 1'b1;
                busy   = 1'b1;
                if (cnt_q == LAST_SLICE) state_d = ST_DONE;
            end
            ST_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Counter wraps 7->0 by itself on the final RUN edge, which is exactly the DONE transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else if (state_q == ST_IDLE && start) begin
            cnt_q   <= '0;
            opa_q   <= a;
            opb_q   <= b;
            sum_q   <= '0;
            carry_q <= cin;
            cout_q  <= 1'b0;
        end else if (state_q == ST_RUN) begin
            sum_q[cnt_q] <= sl_s;
            carry_q      <= sl_c;
            cnt_q        <= cnt_q + SEL_W'(1);
            if (cnt_q == LAST_SLICE) cout_q <= sl_c;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

`ifdef NIBBLE_SEQ_OVF_EN
    // Same-sign operands giving an opposite-sign result == carry into MSB xor carry out of MSB.
    logic ovf_q;
    logic ovf_d;

    assign ovf_d = (opa_q[cnt_q][SLICE_W-1] == opb_q[cnt_q][SLICE_W-1]) &&
                   (sl_s[SLICE_W-1] != opa_q[cnt_q][SLICE_W-1]);

    always_ff @(posedge clk) begin
        if (reset)                                       ovf_q <= 1'b0;
        else if (state_q == ST_IDLE && start)            ovf_q <= 1'b0;
        else if (state_q == ST_RUN && cnt_q == LAST_SLICE) ovf_q <= ovf_d;
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_add_sequencer.sv
// Directed bench for nibble_add_sequencer: reset, sums, ignored start, mid-run abort, overflow.
module tb_nibble_add_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] a, b;
    logic        cin;
    logic [2:0]  sel;
    logic        sel_en, busy, done, cout;
    logic [31:0] sum;
`ifdef NIBBLE_SEQ_OVF_EN
    logic        ovf;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    nibble_add_sequencer #(.SLICE_W(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .sel    (sel),
        .sel_en (sel_en),
        .busy   (busy),
        .done   (done),
        .sum    (sum),
        .cout   (cout)
`ifdef NIBBLE_SEQ_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    endtask

    // Starts an op from IDLE (called at a negedge); optionally pulses start again at sel==inj_at.
    task automatic run_op(input logic [31:0] op_a, input logic [31:0] op_b, input logic op_cin,
                          input logic [31:0] exp_sum, input logic exp_cout, input int inj_at);
        a = op_a; b = op_b; cin = op_cin; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("sel_en[%0d]", i), {31'b0, sel_en}, 32'd1);
            chk($sformatf("sel[%0d]", i), {29'b0, sel}, i);
            chk($sformatf("busy_run[%0d]", i), {31'b0, busy}, 32'd1);
            chk($sformatf("done_run[%0d]", i), {31'b0, done}, 32'd0);
            if (i == inj_at) begin
                a = 32'hDEAD_BEEF; b = 32'h1234_5678; cin = 1'b1; start = 1'b1;
            end
            @(negedge clk);
            start = 1'b0;
        end
        chk("done_pulse", {31'b0, done}, 32'd1);
        chk("busy_done", {31'b0, busy}, 32'd1);
        chk("sel_en_done", {31'b0, sel_en}, 32'd0);
        chk("sum", sum, exp_sum);
        chk("cout", {31'b0, cout}, {31'b0, exp_cout});
        @(negedge clk);
        chk("done_cleared", {31'b0, done}, 32'd0);
        chk("busy_idle", {31'b0, busy}, 32'd0);
        chk("sum_hold", sum, exp_sum);
        chk("cout_hold", {31'b0, cout}, {31'b0, exp_cout});
    endtask

    initial begin
        int n_done;
        reset = 1'b1; start = 1'b1; a = 32'h1; b = 32'h1; cin = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_sel", {29'b0, sel}, 32'd0);
        chk("rst_sel_en", {31'b0, sel_en}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_sum", sum, 32'd0);
        chk("rst_cout", {31'b0, cout}, 32'd0);
`ifdef NIBBLE_SEQ_OVF_EN
        chk("rst_ovf", {31'b0, ovf}, 32'd0);
`endif
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("idle_after_rst", {31'b0, busy}, 32'd0);

        run_op(32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 1'b0, -1);
        run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, -1);
        run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, -1);
        run_op(32'h8000_000F, 32'h8000_0001, 1'b1, 32'h0000_0011, 1'b1, -1);

        // Start pulsed at sel==3 must be dropped: result and single done belong to the first op.
        run_op(32'h0000_0010, 32'h0000_0020, 1'b0, 32'h0000_0030, 1'b0, 3);
        n_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("ignored_start_no_extra_done", n_done, 32'd0);
        chk("ignored_start_sum_hold", sum, 32'h0000_0030);

        // Reset at sel==4 aborts the op with no done.
        a = 32'h0F0F_0F0F; b = 32'h0101_0101; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_sel", {29'b0, sel}, 32'd4);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_sel_en", {31'b0, sel_en}, 32'd0);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_sum", sum, 32'd0);
        chk("abort_cout", {31'b0, cout}, 32'd0);
        n_done = 0;
        repeat (14) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("abort_no_done", n_done, 32'd0);

        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, -1);
`ifdef NIBBLE_SEQ_OVF_EN
        chk("ovf_pos", {31'b0, ovf}, 32'd1);
`endif
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, -1);
`ifdef NIBBLE_SEQ_OVF_EN
        chk("ovf_neg", {31'b0, ovf}, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
